// File: rtl/dp_ram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Round-robin between ports, write-first on same-address read/write collisions,
// read data routed back to the issuing port through a fixed-latency tag pipeline.
module dp_ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [1:0]            a_op,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [1:0]            b_op,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  last_grant
);

    // PrioA: port A wins a plain contention (last grant went to B).
    typedef enum logic {PrioA = 1'b0, PrioB = 1'b1} prio_e;

    localparam logic [1:0] OpWrite = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;

    prio_e                 prio_q;
    logic                  a_req, b_req, collide;
    logic                  gnt_a, gnt_b, gnt_any, gnt_we, rd_gnt;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    logic                  mem_en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    // Tag pipeline: entry k is visible k+1 cycles after the read was accepted.
    logic [RD_LATENCY:0]   pipe_vld_q, pipe_port_q;
    logic                  exit_vld, exit_port;

    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

    // Ops 2 and 3 are NONE and never compete for the memory.
    assign a_req   = a_valid & ((a_op == OpWrite) | (a_op == OpRead));
    assign b_req   = b_valid & ((b_op == OpWrite) | (b_op == OpRead));
    assign collide = a_req & b_req & (a_addr == b_addr) & (a_op != b_op);

    // Grant selection: write-first on collision, otherwise round-robin.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (a_req && b_req) begin
            if (collide) begin
                gnt_a = (a_op == OpWrite);
            end else begin
                gnt_a = (prio_q == PrioA);
            end
            gnt_b = ~gnt_a;
        end else begin
            gnt_a = a_req;
            gnt_b = b_req;
        end
    end

    assign gnt_any   = gnt_a | gnt_b;
    assign gnt_we    = gnt_b ? (b_op == OpWrite) : (a_op == OpWrite);
    assign gnt_addr  = gnt_b ? b_addr : a_addr;
    assign gnt_wdata = gnt_b ? b_wdata : a_wdata;
    assign rd_gnt    = gnt_any & ~gnt_we;

    // NONE is accepted unconditionally; ready is held low during reset.
    assign a_ready = rst_n & a_valid & (~a_req | gnt_a);
    assign b_ready = rst_n & b_valid & (~b_req | gnt_b);

    // Priority FSM: flips toward the port that was not just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PrioA;
        end else if (gnt_a) begin
            prio_q <= PrioB;
        end else if (gnt_b) begin
            prio_q <= PrioA;
        end
    end

    assign last_grant = (prio_q == PrioA);

    // Memory stage: register the granted access toward the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= gnt_any;
            mem_we_q <= gnt_any & gnt_we;
            if (gnt_any) begin
                mem_addr_q  <= gnt_addr;
                mem_wdata_q <= gnt_wdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Read tag pipeline: carries {valid, port} alongside the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_port_q <= '0;
        end else begin
            pipe_vld_q  <= {pipe_vld_q[RD_LATENCY-1:0], rd_gnt};
            pipe_port_q <= {pipe_port_q[RD_LATENCY-1:0], gnt_b};
        end
    end

    assign exit_vld  = pipe_vld_q[RD_LATENCY];
    assign exit_port = pipe_port_q[RD_LATENCY];

    // Return stage: capture RAM data into the owning port, pulse its rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= exit_vld & ~exit_port;
            b_rvalid_q <= exit_vld & exit_port;
            if (exit_vld && !exit_port) begin
                a_rdata_q <= mem_rdata;
            end
            if (exit_vld && exit_port) begin
                b_rdata_q <= mem_rdata;
            end
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule
